// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type selectors and line levels.
// The transmitter and the receiver both import this package.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..prescale-1 and flags the last cycle of each bit.
// A prescale of 0 gives 2^PRESCALE_W cycles per bit through natural wrap of prescale-1.
module uart_baud_cnt #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] cnt_reg;
  logic [PRESCALE_W-1:0] cnt_next;

  assign bit_done = (cnt_reg == (prescale - PRESCALE_W'(1)));

  always_comb begin
    cnt_next = cnt_reg + PRESCALE_W'(1);
    if (clear || bit_done) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional parity, stop bit.
// Frame settings are latched on accept so input changes mid-frame have no effect.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_reg, state_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_type_reg, par_type_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic                  tx_out_reg, tx_out_next;
  logic                  busy_reg, busy_next;
  logic                  parity_bit;
  logic                  bit_done;

  // Counter is held at zero while idle so the start bit gets a full bit time.
  uart_baud_cnt #(
    .PRESCALE_W(PRESCALE_W)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_reg == IDLE),
    .prescale(prescale_reg),
    .bit_done(bit_done)
  );

  assign parity_bit = (par_type_reg == PAR_EVEN) ? (^data_reg) : (~^data_reg);

  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    par_en_next   = par_en_reg;
    par_type_next = par_type_reg;
    prescale_next = prescale_reg;
    bit_idx_next  = bit_idx_reg;

    case (state_reg)
      IDLE: begin
        if (data_valid) begin
          state_next    = START;
          data_next     = p_data;
          par_en_next   = par_en;
          par_type_next = par_type;
          prescale_next = prescale;
          bit_idx_next  = '0;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_reg == LAST_IDX) begin
            bit_idx_next = '0;
            state_next   = par_en_reg ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The line level is registered, so it is derived from where the FSM is going.
    case (state_next)
      START:   tx_out_next = START_BIT;
      DATA:    tx_out_next = data_next[bit_idx_next];
      PARITY:  tx_out_next = parity_bit;
      default: tx_out_next = STOP_BIT;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      prescale_reg <= '0;
      bit_idx_reg  <= '0;
      tx_out_reg   <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      par_en_reg   <= par_en_next;
      par_type_reg <= par_type_next;
      prescale_reg <= prescale_next;
      bit_idx_reg  <= bit_idx_next;
      tx_out_reg   <= tx_out_next;
      busy_reg     <= busy_next;
    end
  end

  assign tx_out = tx_out_reg;
  assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand-written corner sequences,
// and randomized frames decoded by a behavioural receiver.
module tb_uart_tx;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_type;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH(DW),
    .PRESCALE_W(PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_type  (par_type),
    .prescale  (prescale),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] ps;
    int         exp_par;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];
  logic obs_tx[0:1023];
  logic obs_busy[0:1023];
  int   exp_bits[0:11];
  int   exp_n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int bit_time(input logic [5:0] ps);
    return (ps == 6'd0) ? 64 : int'(ps);
  endfunction

  // Reference frame: list of line levels, one per bit time.
  function automatic void build_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones;
    ones  = 0;
    exp_n = 0;
    exp_bits[exp_n] = 0; exp_n++;
    for (int i = 0; i < 8; i++) begin
      exp_bits[exp_n] = int'(d[i]); exp_n++;
      ones += int'(d[i]);
    end
    if (pe) begin
      exp_bits[exp_n] = pt ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
      exp_n++;
    end
    exp_bits[exp_n] = 1; exp_n++;
  endfunction

  // Issue one request at the next posedge and observe the whole frame plus the idle cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] ps, input bit keep_valid, input bit disturb,
                           output int busy_cnt, output int par_obs, output logic [7:0] rx_byte);
    int p;
    int total;
    int act;
    p = bit_time(ps);
    build_frame(d, pe, pt);
    total = exp_n * p;
    p_data = d; par_en = pe; par_type = pt; prescale = ps; data_valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) data_valid = 1'b0;
    for (int k = 0; k < total; k++) begin
      if (disturb && k == p + 2) begin
        p_data = 8'h00; prescale = ps ^ 6'h15; par_type = ~pt; par_en = ~pe; data_valid = 1'b1;
      end
      if (disturb && !keep_valid && k == p + 3) data_valid = 1'b0;
      obs_tx[k]   = tx_out;
      obs_busy[k] = busy;
      @(negedge clk);
    end
    check($sformatf("%s_idle_busy", tag), int'(busy), 0);
    check($sformatf("%s_idle_tx", tag), int'(tx_out), 1);
    for (int b = 0; b < exp_n; b++) begin
      act = exp_bits[b];
      for (int k = b * p; k < (b + 1) * p; k++) begin
        if (int'(obs_tx[k]) != exp_bits[b]) act = int'(obs_tx[k]);
      end
      check($sformatf("%s_bit%0d", tag, b), act, exp_bits[b]);
    end
    busy_cnt = 0;
    for (int k = 0; k < total; k++) busy_cnt += int'(obs_busy[k]);
    check($sformatf("%s_busy_len", tag), busy_cnt, total);
    par_obs = pe ? int'(obs_tx[9 * p + p / 2]) : -1;
    for (int i = 0; i < 8; i++) rx_byte[i] = obs_tx[(1 + i) * p + p / 2];
    $display("frame %s data=%02h pe=%0d pt=%0d ps=%0d busy=%0d rx=%02h",
             tag, d, pe, pt, p, busy_cnt, rx_byte);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int         busy_cnt;
    int         par_obs;
    int         bad;
    logic [7:0] rx;
    logic [7:0] d;
    logic [5:0] ps;
    logic       pe;
    logic       pt;

    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, ps: 6'd8,  exp_par: 0, exp_busy: 80};
    vecs[1] = '{data: 8'h3C, pe: 1'b1, pt: 1'b0, ps: 6'd16, exp_par: 0, exp_busy: 176};
    vecs[2] = '{data: 8'h01, pe: 1'b1, pt: 1'b1, ps: 6'd32, exp_par: 0, exp_busy: 352};
    vecs[3] = '{data: 8'hFF, pe: 1'b1, pt: 1'b1, ps: 6'd4,  exp_par: 1, exp_busy: 44};
    vecs[4] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, ps: 6'd5,  exp_par: 1, exp_busy: 55};
    vecs[5] = '{data: 8'h80, pe: 1'b0, pt: 1'b1, ps: 6'd0,  exp_par: 0, exp_busy: 640};

    // Reset with a pending request: nothing may start.
    rst = 1'b1; data_valid = 1'b1; p_data = 8'hAA; par_en = 1'b0; par_type = 1'b0; prescale = 6'd8;
    repeat (2) @(negedge clk);
    check("rst_tx", int'(tx_out), 1);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0; data_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    check("rst_no_frame", bad, 0);
    $display("reset sequence done bad_cycles=%0d", bad);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].ps,
                1'b0, 1'b0, busy_cnt, par_obs, rx);
      check($sformatf("vec%0d_busy_tab", i), busy_cnt, vecs[i].exp_busy);
      if (vecs[i].pe) check($sformatf("vec%0d_par_tab", i), par_obs, vecs[i].exp_par);
      check($sformatf("vec%0d_rx", i), int'(rx), int'(vecs[i].data));
      @(negedge clk);
    end

    // Back-to-back with data_valid held high, plus an ignored 0x00 request mid-frame.
    run_frame("b2b0", 8'h55, 1'b0, 1'b0, 6'd8, 1'b1, 1'b1, busy_cnt, par_obs, rx);
    check("b2b0_rx", int'(rx), 8'h55);
    run_frame("b2b1", 8'hFF, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, busy_cnt, par_obs, rx);
    check("b2b1_rx", int'(rx), 8'hFF);
    @(negedge clk);

    // Settings changed mid-frame must not alter the frame.
    run_frame("dist", 8'hC3, 1'b1, 1'b1, 6'd16, 1'b0, 1'b1, busy_cnt, par_obs, rx);
    check("dist_rx", int'(rx), 8'hC3);
    @(negedge clk);

    // Reset pulsed in the DATA state.
    p_data = 8'h96; par_en = 1'b1; par_type = 1'b0; prescale = 6'd8; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (8 + 8 * 3 + 2) @(negedge clk);
    check("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", int'(tx_out), 1);
    check("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    check("mid_rst_no_resume", bad, 0);
    $display("mid-frame reset done bad_cycles=%0d", bad);
    run_frame("postrst", 8'h96, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0, busy_cnt, par_obs, rx);
    check("postrst_rx", int'(rx), 8'h96);
    @(negedge clk);

    // Loopback: 10 random bytes at prescale 8/16/32.
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = (i % 3 == 0) ? 6'd8 : ((i % 3 == 1) ? 6'd16 : 6'd32);
      run_frame($sformatf("lb%0d", i), d, pe, pt, ps, 1'b0, 1'b0, busy_cnt, par_obs, rx);
      check($sformatf("lb%0d_rx", i), int'(rx), int'(d));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Random settings, random mid-frame disturbance.
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = 6'($urandom_range(0, 40));
      run_frame($sformatf("rnd%0d", i), d, pe, pt, ps, 1'b0, 1'($urandom), busy_cnt, par_obs, rx);
      check($sformatf("rnd%0d_rx", i), int'(rx), int'(d));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the number of payload bits per frame.
REQ-002 SHALL have parameter PRESCALE_W, default 6, the width of the prescale input.
REQ-003 SHALL have port clk  input  1  oversampled clock, the same clock the receiver uses.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port p_data  input  DATA_WIDTH  parallel byte to transmit.
REQ-006 SHALL have port data_valid  input  1  request qualifier for p_data.
REQ-007 SHALL have port par_en  input  1  enables the parity bit (1 = parity bit present).
REQ-008 SHALL have port par_type  input  1  selects parity: 0 = even, 1 = odd.
REQ-009 SHALL have port prescale  input  PRESCALE_W  clk cycles per serial bit.
REQ-010 SHALL have port tx_out  output  1  serial line, registered, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL send each frame as: start bit 0, then p_data LSB first, then the parity bit if par_en=1, then stop bit 1.
REQ-013 SHALL hold each bit on tx_out for exactly prescale clk cycles; prescale=0 SHALL mean 2^PRESCALE_W cycles (natural counter wrap).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions: IDLE->START on accept; START->DATA after 1 bit time; DATA->PARITY after DATA_WIDTH bits if par_en, else DATA->STOP; PARITY->STOP after 1 bit time; STOP->IDLE after 1 bit time.
REQ-015 SHALL accept a request only at a clk edge where the state is IDLE and data_valid=1; at that edge it SHALL latch p_data, par_en, par_type and prescale.
REQ-016 SHALL drive tx_out=0 and busy=1 from the cycle after the accept edge (1-cycle latency).
REQ-017 SHALL ignore data_valid while busy=1; no queuing, and no frame is corrupted.
REQ-018 SHALL NOT let changes to p_data, par_en, par_type or prescale during a frame affect that frame.
REQ-019 SHALL compute parity as ^data for even and ~^data for odd, from the latched data.
REQ-020 SHALL keep busy high for exactly 10*prescale cycles (par_en=0) or 11*prescale cycles (par_en=1); in the final STOP cycle the FSM SHALL go to IDLE, busy SHALL go low next cycle, and tx_out SHALL stay 1.
REQ-021 SHALL, with data_valid held high continuously, insert exactly one IDLE cycle (busy=0, tx_out=1) between consecutive frames.
REQ-022 SHALL use a bit-time counter that counts 0..prescale-1 and resets at each bit boundary, and a bit index of log2(DATA_WIDTH) bits that wraps only at the DATA exit.

Reset
REQ-023 SHALL, at a clk edge with rst=1, force state IDLE, tx_out=1, busy=0, and clear all counters and latched data.
REQ-024 SHALL abort any frame when rst is asserted mid-frame, with tx_out=1 from the next cycle; no partial frame resumes after rst is released.
REQ-025 SHALL NOT accept a request at an edge where rst=1, even if data_valid=1.

Structure
REQ-026 SHALL take the FSM state encoding, the parity-type constants (PAR_EVEN=0, PAR_ODD=1), and the START_BIT/STOP_BIT values from shared package uart_pkg, which uart_rx also uses.
REQ-027 SHALL place the bit-time counter in sub-module uart_baud_cnt (inputs clk, rst, clear, prescale; output bit_done), reusable by the receiver.

Verification
REQ-028 SHALL cover reset: rst=1 for 2 cycles -> tx_out=1 and busy=0; data_valid=1 during rst -> no frame starts.
REQ-029 SHALL cover prescale=8, par_en=0, p_data=0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles, busy high for 80 cycles.
REQ-030 SHALL cover prescale=16, par_en=1, par_type=0, p_data=0x3C -> 11 bits with parity 0, busy high for 176 cycles; then par_type=1, p_data=0x01, prescale=32 -> parity bit 0, busy high for 352 cycles.
REQ-031 SHALL cover data_valid held high with p_data=0x55 then 0xFF at prescale=8 -> back-to-back frames with exactly 1 idle cycle between them; a 0x00 pulse issued mid-frame is ignored.
REQ-032 SHALL cover p_data, prescale and par_type changed mid-frame -> the frame is unchanged.
REQ-033 SHALL cover rst pulsed during the DATA state -> next cycle tx_out=1 and busy=0, and the next request transmits correctly.
REQ-034 SHALL cover loopback: tx_out connected to uart_rx with matching settings, 10 bytes at prescale 8/16/32 -> each received p_data equals the sent byte with data_valid pulsed once per byte.
